// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cu_pkg
// Brief  : Shared opcodes, control enums and the control bundle type.
// Rev    : 1.0
// ============================================================================
package cu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL  = 4'd8, ALU_SRA = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2
  } result_src_e;

  typedef struct packed {
    logic        RegWrite;
    logic        MemWrite;
    logic        MemRead;
    logic        ALUsrc;
    alu_op_e     ALUctrl;
    result_src_e ResultSrc;
    logic        Branch;
    logic        Jump;
    logic        JumpReg;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // SUB exists only for register-register ops; SRA is selected by funct7[5] on either form
  function automatic alu_op_e alu_op(input logic [2:0] f3, input logic f7b5, input logic is_r);
    alu_op_e op;
    case (f3)
      3'b000:  if (is_r && f7b5) op = ALU_SUB; else op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  if (f7b5) op = ALU_SRA; else op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module : ctrl_decode
// Brief  : Combinational RV32I decode of one instruction into a control bundle.
// Rev    : 1.0
// ============================================================================
module ctrl_decode
  import cu_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output imm_src_e    imm_src_o
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [4:0] w_rd;
  logic       w_f7b5;
  logic       w_unused_instr;

  assign w_opcode       = instr_i[6:0];
  assign w_rd           = instr_i[11:7];
  assign w_funct3       = instr_i[14:12];
  assign w_f7b5         = instr_i[30];
  assign w_unused_instr = ^{instr_i[31], instr_i[29:15]};

  always_comb begin
    ctrl_o        = CTRL_BUBBLE;
    ctrl_o.funct3 = w_funct3;
    imm_src_o     = IMM_I;
    case (w_opcode)
      OP_R: begin
        ctrl_o.RegWrite = 1'b1;
        ctrl_o.ALUctrl  = alu_op(w_funct3, w_f7b5, 1'b1);
        ctrl_o.rd       = w_rd;
      end
      OP_IALU: begin
        ctrl_o.RegWrite = 1'b1;
        ctrl_o.ALUsrc   = 1'b1;
        ctrl_o.ALUctrl  = alu_op(w_funct3, w_f7b5, 1'b0);
        ctrl_o.rd       = w_rd;
      end
      OP_LOAD: begin
        ctrl_o.RegWrite  = 1'b1;
        ctrl_o.MemRead   = 1'b1;
        ctrl_o.ALUsrc    = 1'b1;
        ctrl_o.ResultSrc = RES_MEM;
        ctrl_o.rd        = w_rd;
      end
      OP_STORE: begin
        ctrl_o.MemWrite = 1'b1;
        ctrl_o.ALUsrc   = 1'b1;
        imm_src_o       = IMM_S;
      end
      OP_BRANCH: begin
        ctrl_o.Branch  = 1'b1;
        ctrl_o.ALUctrl = ALU_SUB;
        ctrl_o.illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
        imm_src_o      = IMM_B;
      end
      OP_JAL: begin
        ctrl_o.RegWrite  = 1'b1;
        ctrl_o.Jump      = 1'b1;
        ctrl_o.ResultSrc = RES_PC4;
        ctrl_o.rd        = w_rd;
        imm_src_o        = IMM_J;
      end
      OP_JALR: begin
        ctrl_o.RegWrite  = 1'b1;
        ctrl_o.Jump      = 1'b1;
        ctrl_o.JumpReg   = 1'b1;
        ctrl_o.ALUsrc    = 1'b1;
        ctrl_o.ResultSrc = RES_PC4;
        ctrl_o.rd        = w_rd;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl_o.RegWrite = 1'b1;
        ctrl_o.ALUsrc   = 1'b1;
        ctrl_o.rd       = w_rd;
        imm_src_o       = IMM_U;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
    // Writes to x0 are dropped here so later stages never see a live x0 write
    if (ctrl_o.rd == 5'd0) ctrl_o.RegWrite = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/cu_pipe.sv
`default_nettype none
// ============================================================================
// Module : cu_pipe
// Brief  : Pipelined RV32I control unit: ID decode, ID/EX-EX/MEM-MEM/WB bundles,
//          EX branch resolution and bubble insertion on stall/flush.
// Rev    : 1.0
// ============================================================================
module cu_pipe
  import cu_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter int IMMSRC_W  = 3,
  parameter int RD_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr_id,
  input  logic                 valid_id,
  input  logic                 stall,
  input  logic                 eq_ex,
  input  logic                 lt_ex,
  input  logic                 ltu_ex,
  output logic [IMMSRC_W-1:0]  ImmSrc_id,
  output logic [ALUCTRL_W-1:0] ALUctrl_ex,
  output logic                 ALUsrc_ex,
  output logic                 MemRead_ex,
  output logic [RD_W-1:0]      rd_ex,
  output logic                 PCsrc_ex,
  output logic                 TargetSrc_ex,
  output logic                 flush,
  output logic                 illegal_ex,
  output logic                 MemWrite_mem,
  output logic [RD_W-1:0]      rd_mem,
  output logic                 RegWrite_mem,
  output logic                 RegWrite_wb,
  output logic [1:0]           ResultSrc_wb,
  output logic [RD_W-1:0]      rd_wb
);

  ctrl_t    w_dec;
  imm_src_e w_imm;
  ctrl_t    ex_d, ex_q, mem_q, wb_q;
  logic     w_br_cond;
  logic     w_unused_wb;

  ctrl_decode u_decode (
    .instr_i   (instr_id),
    .ctrl_o    (w_dec),
    .imm_src_o (w_imm)
  );

  always_comb begin
    case (ex_q.funct3)
      3'b000:  w_br_cond = eq_ex;
      3'b001:  w_br_cond = ~eq_ex;
      3'b100:  w_br_cond = lt_ex;
      3'b101:  w_br_cond = ~lt_ex;
      3'b110:  w_br_cond = ltu_ex;
      3'b111:  w_br_cond = ~ltu_ex;
      default: w_br_cond = 1'b0;
    endcase
  end

  assign PCsrc_ex = ex_q.Jump | (ex_q.Branch & w_br_cond);
  assign flush    = PCsrc_ex;

  // Stall and flush both collapse to a single bubble into ID/EX
  always_comb begin
    ex_d = w_dec;
    if (stall || PCsrc_ex || !valid_id) ex_d = CTRL_BUBBLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= CTRL_BUBBLE;
      mem_q <= CTRL_BUBBLE;
      wb_q  <= CTRL_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ImmSrc_id    = IMMSRC_W'(w_imm);
  assign ALUctrl_ex   = ALUCTRL_W'(ex_q.ALUctrl);
  assign ALUsrc_ex    = ex_q.ALUsrc;
  assign MemRead_ex   = ex_q.MemRead;
  assign rd_ex        = RD_W'(ex_q.rd);
  assign TargetSrc_ex = ex_q.JumpReg;
  assign illegal_ex   = ex_q.illegal;
  assign MemWrite_mem = mem_q.MemWrite;
  assign rd_mem       = RD_W'(mem_q.rd);
  assign RegWrite_mem = mem_q.RegWrite;
  assign RegWrite_wb  = wb_q.RegWrite;
  assign ResultSrc_wb = wb_q.ResultSrc;
  assign rd_wb        = RD_W'(wb_q.rd);
  assign w_unused_wb  = ^wb_q;

endmodule
`default_nettype wire

// File: tb/tb_cu_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_cu_pipe
// Brief  : Self-checking bench for cu_pipe: timeline reference model plus directed literals.
// Rev    : 1.0
// ============================================================================
module tb_cu_pipe;

  localparam logic [31:0] C_ADD   = 32'h002081B3;
  localparam logic [31:0] C_SUB   = 32'h402081B3;
  localparam logic [31:0] C_LW    = 32'h0000A283;
  localparam logic [31:0] C_SW    = 32'h0020A223;
  localparam logic [31:0] C_BEQ   = 32'h00208463;
  localparam logic [31:0] C_BLT   = 32'h0020C463;
  localparam logic [31:0] C_JAL   = 32'h008000EF;
  localparam logic [31:0] C_JALR  = 32'h000100E7;
  localparam logic [31:0] C_ADDI0 = 32'h00100013;
  localparam logic [31:0] C_ILL   = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_id = 32'h0;
  logic        valid_id = 1'b0, stall = 1'b0, eq_ex = 1'b0, lt_ex = 1'b0, ltu_ex = 1'b0;
  logic [2:0]  ImmSrc_id;
  logic [3:0]  ALUctrl_ex;
  logic        ALUsrc_ex, MemRead_ex, PCsrc_ex, TargetSrc_ex, flush, illegal_ex;
  logic        MemWrite_mem, RegWrite_mem, RegWrite_wb;
  logic [4:0]  rd_ex, rd_mem, rd_wb;
  logic [1:0]  ResultSrc_wb;

  int checks = 0;
  int failures = 0;

  cu_pipe #(.ALUCTRL_W(4), .IMMSRC_W(3), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .instr_id(instr_id), .valid_id(valid_id), .stall(stall),
    .eq_ex(eq_ex), .lt_ex(lt_ex), .ltu_ex(ltu_ex), .ImmSrc_id(ImmSrc_id),
    .ALUctrl_ex(ALUctrl_ex), .ALUsrc_ex(ALUsrc_ex), .MemRead_ex(MemRead_ex), .rd_ex(rd_ex),
    .PCsrc_ex(PCsrc_ex), .TargetSrc_ex(TargetSrc_ex), .flush(flush), .illegal_ex(illegal_ex),
    .MemWrite_mem(MemWrite_mem), .rd_mem(rd_mem), .RegWrite_mem(RegWrite_mem),
    .RegWrite_wb(RegWrite_wb), .ResultSrc_wb(ResultSrc_wb), .rd_wb(rd_wb)
  );

  always #5 clk = ~clk;

  // kind: 0 plain, 1 conditional branch, 2 JAL, 3 JALR; imm = -1 means don't-care
  typedef struct {
    int rw, mw, mr, asrc, alu, res, kind, f3, rd, ill, imm;
  } exp_t;

  exp_t hist[3];   // expected bundle now in EX, MEM, WB
  exp_t bub, adm, dcur;
  bit   tk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mdec(input logic [31:0] ins);
    exp_t e;
    int   tab[8];
    int   f3, rd;
    logic [6:0] op;
    bit   f7;
    tab = '{0, 7, 5, 6, 4, 8, 3, 2};
    e = '{default: 0};
    op = ins[6:0]; f3 = int'(ins[14:12]); rd = int'(ins[11:7]); f7 = ins[30];
    e.f3 = f3; e.imm = -1;
    if (op == 7'b0110011) begin
      e.rw = 1; e.rd = rd; e.alu = tab[f3];
      if (f7 && f3 == 0) e.alu = 1;
      if (f7 && f3 == 5) e.alu = 9;
    end else if (op == 7'b0010011) begin
      e.rw = 1; e.rd = rd; e.asrc = 1; e.imm = 0; e.alu = tab[f3];
      if (f7 && f3 == 5) e.alu = 9;
    end else if (op == 7'b0000011) begin
      e.rw = 1; e.rd = rd; e.mr = 1; e.asrc = 1; e.res = 1; e.imm = 0;
    end else if (op == 7'b0100011) begin
      e.mw = 1; e.asrc = 1; e.imm = 1;
    end else if (op == 7'b1100011) begin
      e.kind = 1; e.alu = 1; e.imm = 2; e.ill = (f3 == 2 || f3 == 3) ? 1 : 0;
    end else if (op == 7'b1101111) begin
      e.rw = 1; e.rd = rd; e.kind = 2; e.res = 2; e.imm = 4;
    end else if (op == 7'b1100111) begin
      e.rw = 1; e.rd = rd; e.kind = 3; e.res = 2; e.asrc = 1; e.imm = 0;
    end else if (op == 7'b0110111 || op == 7'b0010111) begin
      e.rw = 1; e.rd = rd; e.asrc = 1; e.imm = 3;
    end else begin
      e.ill = 1;
    end
    if (e.rd == 0) e.rw = 0;
    return e;
  endfunction

  function automatic bit mtaken(input exp_t e, input bit eq, input bit lt, input bit ltu);
    if (e.kind == 2 || e.kind == 3) return 1'b1;
    if (e.kind != 1) return 1'b0;
    case (e.f3)
      0: return eq;
      1: return !eq;
      4: return lt;
      5: return !lt;
      6: return ltu;
      7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  initial bub = '{default: 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) hist[i] = bub;
    end else begin
      if (stall || !valid_id || mtaken(hist[0], eq_ex, lt_ex, ltu_ex)) adm = bub;
      else adm = mdec(instr_id);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = adm;
    end
  end

  always @(negedge clk) begin
    tk = mtaken(hist[0], eq_ex, lt_ex, ltu_ex);
    chk("ALUctrl_ex", ALUctrl_ex, hist[0].alu);
    chk("ALUsrc_ex", ALUsrc_ex, hist[0].asrc);
    chk("MemRead_ex", MemRead_ex, hist[0].mr);
    chk("rd_ex", rd_ex, hist[0].rd);
    chk("PCsrc_ex", PCsrc_ex, tk);
    chk("flush", flush, tk);
    chk("TargetSrc_ex", TargetSrc_ex, (hist[0].kind == 3) ? 1 : 0);
    chk("illegal_ex", illegal_ex, hist[0].ill);
    chk("MemWrite_mem", MemWrite_mem, hist[1].mw);
    chk("rd_mem", rd_mem, hist[1].rd);
    chk("RegWrite_mem", RegWrite_mem, hist[1].rw);
    chk("RegWrite_wb", RegWrite_wb, hist[2].rw);
    chk("ResultSrc_wb", ResultSrc_wb, hist[2].res);
    chk("rd_wb", rd_wb, hist[2].rd);
    dcur = mdec(instr_id);
    if (valid_id && dcur.imm >= 0) chk("ImmSrc_id", ImmSrc_id, dcur.imm);
  end

  // Inputs change 1 unit after the rising edge; returns 4 units after it
  task automatic step(input logic [31:0] ins, input bit v, input bit st,
                      input bit eq, input bit lt, input bit ltu);
    @(posedge clk);
    #1;
    instr_id = ins; valid_id = v; stall = st; eq_ex = eq; lt_ex = lt; ltu_ex = ltu;
    #3;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ALUctrl_ex"}, ALUctrl_ex, 0);
    chk({tag, "_MemRead_ex"}, MemRead_ex, 0);
    chk({tag, "_rd_ex"}, rd_ex, 0);
    chk({tag, "_PCsrc_ex"}, PCsrc_ex, 0);
    chk({tag, "_illegal_ex"}, illegal_ex, 0);
    chk({tag, "_RegWrite_mem"}, RegWrite_mem, 0);
    chk({tag, "_rd_mem"}, rd_mem, 0);
    chk({tag, "_MemWrite_mem"}, MemWrite_mem, 0);
    chk({tag, "_RegWrite_wb"}, RegWrite_wb, 0);
    chk({tag, "_ResultSrc_wb"}, ResultSrc_wb, 0);
    chk({tag, "_rd_wb"}, rd_wb, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    step(C_ADD, 1, 0, 0, 0, 0);
    step(C_SUB, 1, 0, 0, 0, 0);
    chk("add_ALUctrl", ALUctrl_ex, 0); chk("add_ALUsrc", ALUsrc_ex, 0); chk("add_rd_ex", rd_ex, 3);
    step(C_LW, 1, 0, 0, 0, 0);
    chk("sub_ALUctrl", ALUctrl_ex, 1); chk("lw_ImmSrc", ImmSrc_id, 0);
    step(32'h0, 0, 0, 0, 0, 0);
    chk("lw_MemRead", MemRead_ex, 1); chk("lw_ALUsrc", ALUsrc_ex, 1);
    chk("add_RegWrite_wb", RegWrite_wb, 1); chk("add_rd_wb", rd_wb, 3); chk("add_ResultSrc", ResultSrc_wb, 0);
    step(32'h0, 0, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0, 0);
    chk("lw_ResultSrc_wb", ResultSrc_wb, 1); chk("lw_rd_wb", rd_wb, 5);

    step(C_BEQ, 1, 0, 0, 0, 0);
    step(C_ADD, 1, 0, 1, 0, 0);
    chk("beq_taken", PCsrc_ex, 1); chk("beq_flush", flush, 1);
    step(32'h0, 0, 0, 0, 0, 0);
    chk("squash_rd_ex", rd_ex, 0); chk("squash_PCsrc", PCsrc_ex, 0);
    step(C_BEQ, 1, 0, 0, 0, 0);
    step(C_ADD, 1, 0, 0, 0, 0);
    chk("beq_not_taken", PCsrc_ex, 0);
    step(32'h0, 0, 0, 0, 0, 0);
    chk("after_beq_rd_ex", rd_ex, 3);
    step(C_BLT, 1, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 1, 0);
    chk("blt_taken", PCsrc_ex, 1);
    step(C_BLT, 1, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0, 0);
    chk("blt_not_taken", PCsrc_ex, 0);

    step(C_LW, 1, 0, 0, 0, 0);
    step(C_ADD, 1, 1, 0, 0, 0);
    chk("stall_lw_MemRead", MemRead_ex, 1);
    step(C_ADD, 1, 0, 0, 0, 0);
    chk("stall_bubble_rd", rd_ex, 0); chk("stall_bubble_MemRead", MemRead_ex, 0);
    step(32'h0, 0, 0, 0, 0, 0);
    chk("stall_add_rd_ex", rd_ex, 3);

    step(C_ADDI0, 1, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0, 0);
    chk("x0_RegWrite_mem", RegWrite_mem, 0);
    step(C_ILL, 1, 0, 0, 0, 0);
    chk("x0_RegWrite_wb", RegWrite_wb, 0);
    step(C_SW, 1, 0, 0, 0, 0);
    chk("ill_flag", illegal_ex, 1); chk("sw_ImmSrc", ImmSrc_id, 1);
    step(C_JAL, 1, 0, 0, 0, 0);
    chk("ill_MemWrite_mem", MemWrite_mem, 0); chk("ill_RegWrite_mem", RegWrite_mem, 0);
    chk("jal_ImmSrc", ImmSrc_id, 4);
    step(32'h0, 0, 0, 0, 0, 0);
    chk("sw_MemWrite_mem", MemWrite_mem, 1); chk("jal_taken", PCsrc_ex, 1);
    chk("jal_TargetSrc", TargetSrc_ex, 0); chk("ill_RegWrite_wb", RegWrite_wb, 0);
    step(C_JALR, 1, 0, 0, 0, 0);
    chk("jalr_ImmSrc", ImmSrc_id, 0);
    step(32'h0, 0, 0, 0, 0, 0);
    chk("jalr_taken", PCsrc_ex, 1); chk("jalr_TargetSrc", TargetSrc_ex, 1);
    chk("jal_ResultSrc_wb", ResultSrc_wb, 2); chk("jal_rd_wb", rd_wb, 1);
    step(32'h0, 0, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0, 0);

    step(C_LW, 1, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0, 0);
    step(32'h0, 0, 0, 0, 0, 0);
    chk("pre_rst_RegWrite_mem", RegWrite_mem, 1); chk("pre_rst_rd_mem", rd_mem, 5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    step(32'h0, 0, 0, 0, 0, 0);
    chk("rst_no_wb", RegWrite_wb, 0);
    rst = 1'b0;
    step(32'h0, 0, 0, 0, 0, 0);
    chk("post_rst_no_wb", RegWrite_wb, 0);
    step(32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cu_pipe.md
Name: cu_pipe

Overview:
Pipelined RV32I control unit, successor to the single-cycle control unit. Decodes the instruction held in ID and carries control bundles through the ID/EX, EX/MEM and MEM/WB registers. Resolves all six branch conditions plus JAL/JALR in EX from ALU flags. Supplies bubble insertion on stall and flush, and exposes rd per stage for the hazard unit.

Parameters:
ALUCTRL_W, 4, width of ALUctrl; must be at least 4.
IMMSRC_W, 3, width of ImmSrc; must be at least 3.
RD_W, 5, register index width.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
instr_id  in  32  instruction currently held in IF/ID
valid_id  in  1  instr_id holds a real instruction
stall  in  1  hazard unit request: hold IF/ID, inject a bubble into ID/EX
eq_ex  in  1  EX operand A == operand B
lt_ex  in  1  EX A < B, signed
ltu_ex  in  1  EX A < B, unsigned
ImmSrc_id  out  IMMSRC_W  sign-extend select for ID; combinational
ALUctrl_ex  out  ALUCTRL_W  ALU operation
ALUsrc_ex  out  1  1 selects immediate operand
MemRead_ex  out  1  EX holds a load; used for load-use detection
rd_ex  out  RD_W  destination register in EX
PCsrc_ex  out  1  redirect PC to the target computed in EX
TargetSrc_ex  out  1  0 = PC+imm, 1 = rs1+imm (JALR)
flush  out  1  squash IF/ID; equals PCsrc_ex
illegal_ex  out  1  EX holds an unsupported opcode
MemWrite_mem  out  1  data memory write enable
rd_mem  out  RD_W  destination register in MEM
RegWrite_mem  out  1  MEM will write the register file; for forwarding
RegWrite_wb  out  1  register file write enable
ResultSrc_wb  out  2  0 = ALU, 1 = memory, 2 = PC+4
rd_wb  out  RD_W  write-back register index

Behaviour:
- Reset: every pipeline register holds a bubble. All registered outputs read 0. rd_* = 0, ResultSrc_wb = 0. Reset takes effect mid-instruction with no completion.
- Supported opcodes: R (0110011), I-ALU (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011), JAL (1101111), JALR (1100111), LUI (0110111), AUIPC (0010111). Any other opcode with valid_id=1 sets illegal_ex and all write enables = 0.
- ALUctrl encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9.
  - SUB only for R-type with funct7[5]=1. SRA for R-type or I-type when funct7[5]=1.
  - Load, store, JALR, AUIPC and LUI use ADD.
  - Branches use SUB; their flags come from the comparator inputs.
- ImmSrc encoding: I=0, S=1, B=2, U=3, J=4. Combinational from instr_id; the value for R-type is don't-care.
- Latency: an instruction in ID at cycle n has its EX controls valid in n+1, MEM in n+2, WB in n+3. The only combinational output is ImmSrc_id.
- Branch resolution in EX (combinational from the registered bundle and the flags):
  - funct3 000 BEQ taken on eq.
  - 001 BNE taken on !eq.
  - 100 BLT taken on lt.
  - 101 BGE taken on !lt.
  - 110 BLTU taken on ltu.
  - 111 BGEU taken on !ltu.
  - 010 and 011 are illegal and never taken.
  - JAL and JALR are always taken. TargetSrc_ex = 1 only for JALR.
- Flush: when PCsrc_ex=1, the next ID/EX load is a bubble (the instruction in ID is squashed). EX/MEM advances normally.
- Stall: ID/EX loads a bubble. EX/MEM and MEM/WB advance. Stall together with flush gives a bubble; flush has priority (same effect, counted once).
- valid_id=0 loads a bubble.
- rd = x0 forces RegWrite to 0 at decode, so the MEM/WB value is 0.
- Stores and branches: RegWrite=0, rd forced to 0.
- JAL/JALR: ResultSrc=2. Loads: ResultSrc=1.

Decomposition:
- Package cu_pkg holds:
  - opcode localparams;
  - enums alu_op_e, imm_src_e, result_src_e;
  - packed struct ctrl_t {RegWrite, MemWrite, MemRead, ALUsrc, ALUctrl, ResultSrc, Branch, Jump, JumpReg, funct3, rd, illegal};
  - the constant CTRL_BUBBLE (all zero).
- Sub-module ctrl_decode: purely combinational, instr -> ctrl_t plus ImmSrc.
- cu_pipe holds the three stage registers, bubble muxing and branch resolution.

Test Plan:
- Reset release, then add x3,x1,x2 (0x002081B3) for 1 cycle -> next cycle ALUctrl_ex=0, ALUsrc_ex=0, rd_ex=3. Two cycles later RegWrite_wb=1, rd_wb=3, ResultSrc_wb=0.
- sub 0x402081B3 -> ALUctrl_ex=1. lw x5,0(x1) (0x0000A283) -> ImmSrc_id=0, MemRead_ex=1, ALUsrc_ex=1, ResultSrc_wb=1, rd_wb=5.
- beq 0x00208463 with eq_ex=1 -> PCsrc_ex=1, flush=1, and the next ID/EX is a bubble. With eq_ex=0 -> PCsrc_ex=0. blt 0x0020C463 with lt_ex=1 and eq_ex=0 -> taken; with lt_ex=0 -> not taken.
- stall=1 for 1 cycle during lw followed by add -> EX shows a bubble (all enables 0, rd_ex=0), then add enters EX the following cycle.
- addi x0,x0,1 (0x00100013) -> RegWrite_wb stays 0. Opcode 0x0000007F -> illegal_ex=1 and no writes.
- Assert rst while lw is in MEM -> all outputs 0 immediately, with no WB write afterwards.
